// File: rtl/complex_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential complex multiplier.
// The master is the core sequencer. The slave is the multiplier.
interface complex_mul_seq_if #(
  parameter int W = 4
);
  logic           start;
  logic [2*W-1:0] in1;
  logic [2*W-1:0] in2;
  logic [2*W-1:0] out;
  logic           busy;
  logic           done;
  logic           ovf;

  modport master (
    output start, in1, in2,
    input  out, busy, done, ovf
  );

  modport slave (
    input  start, in1, in2,
    output out, busy, done, ovf
  );
endinterface

// File: rtl/complex_mul_seq.sv
// Sequential signed complex multiplier for packed {re, im} operands.
// One shared W x W signed multiplier produces the four partial products over
// four cycles. The result is saturated or wrapped to W bits per part.
module complex_mul_seq #(
  parameter int W        = 4,
  parameter bit SATURATE = 1'b1
) (
  input logic clk,
  input logic rst_n,
  complex_mul_seq_if.slave bus
);

  localparam int AW = 2*W + 1;

  // The representable W-bit range, expressed at accumulator width and at part width.
  localparam logic signed [AW-1:0] ACC_MAX  = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN  = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  PART_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  PART_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd2} state_t;

  state_t                state;
  logic [1:0]            cnt;
  logic signed [W-1:0]   a_re, a_im, b_re, b_im;
  logic signed [AW-1:0]  acc_re, acc_im;
  logic signed [W-1:0]   mul_x, mul_y;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic [2*W-1:0]        out_q;
  logic                  busy_q, done_q, ovf_q;
  logic                  accept;

  // True when an accumulator value is inside the W-bit signed range.
  function automatic logic fits_w(input logic signed [AW-1:0] v);
    return (v <= ACC_MAX) && (v >= ACC_MIN);
  endfunction

  // Reduces an accumulator to W bits: clamp when saturating, else keep the low bits.
  function automatic logic signed [W-1:0] to_w(input logic signed [AW-1:0] v);
    if (SATURATE) begin
      if (v > ACC_MAX) return PART_MAX;
      if (v < ACC_MIN) return PART_MIN;
    end
    return v[W-1:0];
  endfunction

  assign accept = (state == IDLE) && bus.start;

  // Operands are captured only on the accepting edge, so input changes while busy are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_re <= bus.in1[2*W-1:W];
      a_im <= bus.in1[W-1:0];
      b_re <= bus.in2[2*W-1:W];
      b_im <= bus.in2[W-1:0];
    end
  end

  // Steer the shared multiplier to the partial product for this step.
  always_comb begin
    mul_x = a_re;
    mul_y = b_re;
    case (cnt)
      2'd0:    begin mul_x = a_re; mul_y = b_re; end
      2'd1:    begin mul_x = a_im; mul_y = b_im; end
      2'd2:    begin mul_x = a_re; mul_y = b_im; end
      default: begin mul_x = a_im; mul_y = b_re; end
    endcase
  end

  assign prod     = mul_x * mul_y;
  assign prod_ext = {prod[2*W-1], prod};

  // Control FSM, accumulation and the registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      acc_re <= '0;
      acc_im <= '0;
      out_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= 2'd0;
            busy_q <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          case (cnt)
            2'd0:    acc_re <= acc_re + prod_ext;
            2'd1:    acc_re <= acc_re - prod_ext;
            2'd2:    acc_im <= acc_im + prod_ext;
            default: acc_im <= acc_im + prod_ext;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= FIN;
        end
        FIN: begin
          out_q  <= {to_w(acc_re), to_w(acc_im)};
          ovf_q  <= !fits_w(acc_re) || !fits_w(acc_im);
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_complex_mul_seq.sv
// Directed bench for complex_mul_seq: one saturating and one wrapping instance
// driven with identical stimulus.
module tb_complex_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  complex_mul_seq_if #(.W(4)) sb ();
  complex_mul_seq_if #(.W(4)) wb ();

  complex_mul_seq #(.W(4), .SATURATE(1'b1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sb));
  complex_mul_seq #(.W(4), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(wb));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic st);
    sb.in1 = a; sb.in2 = b; sb.start = st;
    wb.in1 = a; wb.in2 = b; wb.start = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: accept, four busy cycles, result edge, done drop.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic eos,
                       input logic [7:0] ew, input logic eow);
    int bad;
    bad = 0;
    drive(a, b, 1'b1);
    tick();
    drive(~a, ~b, 1'b0);
    chk({tag, "_busy_e0"}, {15'd0, sb.busy}, 16'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (sb.busy !== 1'b1 || sb.done !== 1'b0 || wb.busy !== 1'b1) bad++;
    end
    chk({tag, "_busy_e1_e4"}, bad[15:0], 16'd0);
    tick();
    chk({tag, "_done"}, {14'd0, sb.done, wb.done}, 16'h3);
    chk({tag, "_busy_e5"}, {14'd0, sb.busy, wb.busy}, 16'h0);
    chk({tag, "_out_sat"}, {8'd0, sb.out}, {8'd0, es});
    chk({tag, "_ovf_sat"}, {15'd0, sb.ovf}, {15'd0, eos});
    chk({tag, "_out_wrap"}, {8'd0, wb.out}, {8'd0, ew});
    chk({tag, "_ovf_wrap"}, {15'd0, wb.ovf}, {15'd0, eow});
    tick();
    chk({tag, "_done_drop"}, {14'd0, sb.done, wb.done}, 16'h0);
  endtask

  logic [7:0] p_a [3];
  logic [7:0] p_b [3];
  logic [7:0] p_s [3];
  logic [7:0] p_w [3];
  int         dones;

  initial begin
    drive(8'h00, 8'h00, 1'b0);
    #2;
    chk("reset_out", {sb.out, wb.out}, 16'h0000);
    chk("reset_flags", {10'd0, sb.busy, sb.done, sb.ovf, wb.busy, wb.done, wb.ovf}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // (1+1i)*(0+1i) = -1+1i
    do_op("i_times", 8'h11, 8'h01, 8'hF1, 1'b0, 8'hF1, 1'b0);
    // (-1-1i)^2 = 0+2i
    do_op("neg_sq", 8'hFF, 8'hFF, 8'h02, 1'b0, 8'h02, 1'b0);
    // (-8)*(-8) = 64: clamps to 7, wraps to 0
    do_op("min_sq", 8'h80, 8'h80, 8'h70, 1'b1, 8'h00, 1'b1);
    // (3+7i)*(-8+1i) = -31-53i
    do_op("both_ovf", 8'h37, 8'h81, 8'h88, 1'b1, 8'h1B, 1'b1);

    // start held high: accepted every 6 cycles, operands change during busy
    p_a[0] = 8'h11; p_b[0] = 8'h01; p_s[0] = 8'hF1; p_w[0] = 8'hF1;
    p_a[1] = 8'hFF; p_b[1] = 8'hFF; p_s[1] = 8'h02; p_w[1] = 8'h02;
    p_a[2] = 8'h37; p_b[2] = 8'h81; p_s[2] = 8'h88; p_w[2] = 8'h1B;
    drive(p_a[0], p_b[0], 1'b1);
    dones = 0;
    for (int c = 0; c < 18; c++) begin
      tick();
      if (sb.done === 1'b1) dones++;
      if (c % 6 == 0) begin
        chk($sformatf("stream_busy_c%0d", c), {15'd0, sb.busy}, 16'd1);
        if (c / 6 < 2) drive(p_a[c/6 + 1], p_b[c/6 + 1], 1'b1);
        else drive(8'h80, 8'h80, 1'b1);
      end
      if (c % 6 == 5) begin
        chk($sformatf("stream_done_c%0d", c), {15'd0, sb.done}, 16'd1);
        chk($sformatf("stream_out_c%0d", c), {sb.out, wb.out}, {p_s[c/6], p_w[c/6]});
      end else begin
        chk($sformatf("stream_nodone_c%0d", c), {15'd0, sb.done}, 16'd0);
      end
      if (c == 17) drive(8'h00, 8'h00, 1'b0);
    end
    chk("stream_done_count", dones[15:0], 16'd3);
    tick();
    chk("stream_idle", {15'd0, sb.busy}, 16'd0);

    // reset in the middle of an operation
    drive(8'h11, 8'h01, 1'b1);
    tick();
    drive(8'h11, 8'h01, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {sb.out, wb.out}, 16'h0000);
    chk("midrst_flags", {10'd0, sb.busy, sb.done, sb.ovf, wb.busy, wb.done, wb.ovf}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (sb.done !== 1'b0 || wb.done !== 1'b0) dones++;
    end
    chk("midrst_no_done", dones[15:0], 16'd0);
    do_op("after_rst", 8'h37, 8'h81, 8'h88, 1'b1, 8'h1B, 1'b1);

    // start while busy is ignored
    drive(8'hFF, 8'hFF, 1'b1);
    tick();
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 3) drive(8'h80, 8'h80, 1'b1);
      else drive(8'h80, 8'h80, 1'b0);
      tick();
      if (sb.done === 1'b1) dones++;
    end
    chk("busy_start_dones", dones[15:0], 16'd1);
    chk("busy_start_out", {sb.out, wb.out}, 16'h0202);
    chk("busy_start_ovf", {14'd0, sb.ovf, wb.ovf}, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_mul_seq.md
Name: complex_mul_seq

Overview:
- Sequential signed complex multiplier for the Mini-core ALU. It is the multiply companion to the packed-complex add/sub path.
- Operands use the same packed format: {re, im}, with each part a two's-complement W-bit field and re in the upper half.
- A single shared W x W signed multiplier computes the four partial products over four cycles. The result is returned in the same packed format, saturated or wrapped per parameter.
- start/busy/done handshake so the core sequencer can stall on it.

Parameters:
- W, 4, width of each real/imaginary part; operands and result are 2W bits.
- SATURATE, 1, 1 = clamp each result part to [-2^(W-1), 2^(W-1)-1]; 0 = keep the low W bits (wrap).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- in1  input  2W  operand A, packed {a_re, a_im}, signed parts.
- in2  input  2W  operand B, packed {b_re, b_im}, signed parts.
- out  output  2W  product, packed {p_re, p_im}; held until the next result.
- busy  output  1  high from the accepting edge through the final compute edge.
- done  output  1  one-cycle pulse when out/ovf are updated.
- ovf  output  1  result of the last operation did not fit in W bits in either part.

Behaviour:
- Reset: clk and rst_n are named as in the codebase. Reset is asynchronous and active-low. While rst_n=0:
  - out=0, busy=0, done=0, ovf=0, state=IDLE, counter=0, accumulators=0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- Arithmetic:
  - p_re = a_re*b_re - a_im*b_im; p_im = a_re*b_im + a_im*b_re.
  - Each product is 2W bits signed; the accumulators are 2W+1 bits signed. No intermediate overflow is possible.
- States: IDLE, MUL, FIN.
- IDLE:
  - busy=0.
  - On an edge with start=1, latch in1/in2 into operand registers, clear both accumulators, set cnt=0, go to MUL. busy=1 from that edge (E0).
  - start=0: stay in IDLE.
- MUL: one product per edge, E1..E4.
  - cnt=0: acc_re += a_re*b_re.
  - cnt=1: acc_re -= a_im*b_im.
  - cnt=2: acc_im += a_re*b_im.
  - cnt=3: acc_im += a_im*b_re, then go to FIN.
- FIN (edge E5):
  - Convert both accumulators to W bits per SATURATE.
  - Register out. Set ovf=1 if either accumulator lies outside the W-bit signed range; this applies in either mode.
  - done=1 for exactly the cycle after E5.
  - Return to IDLE with busy=0.
- Latency: start accepted at E0, result visible after E5 (5 cycles). Maximum throughput is one operation per 6 cycles.
- Operand timing: in1/in2 are sampled only at the accepting edge. Changes while busy have no effect.
- start while busy=1: ignored, not queued.
- start in the done cycle: accepted, since the block is already in IDLE. done then drops and busy rises on that edge. out keeps the previous result until the new E5.
- out and ovf change only at FIN or reset.

Test Plan:
- Reset, then in1=0x11 (1+1i), in2=0x01 (0+1i), start one cycle -> busy high for 5 cycles, done pulse at cycle 5, out=0xF1 (-1+1i), ovf=0.
- in1=0xFF (-1-1i), in2=0xFF -> out=0x02 (0+2i), ovf=0. Also (-8+0i)*(-8+0i): in1=0x80, in2=0x80 -> re=64 saturates to 0x70, ovf=1.
- in1=0x37, in2=0x81, SATURATE=1 -> raw re=-31, im=-53, out=0x88, ovf=1. Same operands with SATURATE=0 -> out=0x1B, ovf=1.
- Hold start high continuously with a fresh operand pair each time -> a new operation is accepted every 6 cycles. Operand changes during busy do not alter the result. done is never wider than one cycle.
- Assert rst_n=0 at cycle 2 of an operation -> all outputs go to 0 immediately and no done pulse follows. After release, a new start gives a correct result.
- Issue start during busy -> it is ignored: the number of done pulses equals the number of accepted starts.
